// File: rtl/audio_ctrl_pkg.sv
// Shared types and default sizing for the click-free audio source sequencer.
// State codes are visible to software through the status register, so they are fixed.
package audio_ctrl_pkg;

    localparam int DEF_DATA_W        = 24;
    localparam int DEF_RAMP_LOG2     = 6;
    localparam int DEF_SETTLE_FRAMES = 2;
    localparam int FULL_GAIN         = 1 << DEF_RAMP_LOG2;

    typedef enum logic [2:0] {
        ST_MUTE     = 3'd0,
        ST_FADE_IN  = 3'd1,
        ST_PLAY     = 3'd2,
        ST_FADE_OUT = 3'd3,
        ST_SWITCH   = 3'd4
    } state_e;

endpackage

// File: rtl/audio_gain_stage.sv
// One channel of the fader: registered signed sample times unsigned gain,
// scaled back by 2^RAMP_LOG2 so that full gain passes the sample unchanged.
module audio_gain_stage
    import audio_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAMP_LOG2 = DEF_RAMP_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_din,
    input  logic [RAMP_LOG2:0] i_gain,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_dout
);

    localparam int PROD_W = DATA_W + RAMP_LOG2 + 1;

    logic signed [PROD_W-1:0] w_din_ext;
    logic signed [PROD_W-1:0] w_gain_ext;
    logic signed [PROD_W-1:0] w_product;

    logic              r_valid;
    logic [DATA_W-1:0] r_dout;

    // Gain is zero-extended so it is always treated as non-negative.
    assign w_din_ext  = {{(RAMP_LOG2 + 1){i_din[DATA_W-1]}}, i_din};
    assign w_gain_ext = {{DATA_W{1'b0}}, i_gain};
    assign w_product  = w_din_ext * w_gain_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_dout <= DATA_W'(w_product >>> RAMP_LOG2);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_dout  = r_dout;

endmodule

// File: rtl/audio_source_switch_ctrl.sv
// Owns the audio output mux select and sequences every source change as
// fade-out, switch, settle, fade-in, so the I2S stream never steps abruptly.
module audio_source_switch_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int DATA_W        = DEF_DATA_W,
    parameter int RAMP_LOG2     = DEF_RAMP_LOG2,
    parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [1:0]        sel_req,
    output logic [1:0]        mux_sel,
    input  logic              l_din_valid,
    input  logic              r_din_valid,
    input  logic [DATA_W-1:0] l_din,
    input  logic [DATA_W-1:0] r_din,
    output logic              l_dout_valid,
    output logic              r_dout_valid,
    output logic [DATA_W-1:0] l_dout,
    output logic [DATA_W-1:0] r_dout,
    output logic              busy,
    output logic [2:0]        state
);

    localparam int GAIN_W = RAMP_LOG2 + 1;
    localparam int CNT_W  = $clog2(SETTLE_FRAMES + 1);
    localparam logic [GAIN_W-1:0] FULL        = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_FRAMES);

    state_e            r_state;
    logic [GAIN_W-1:0] r_gain;
    logic [1:0]        r_mux_sel;
    logic [CNT_W-1:0]  r_settle;
    logic              r_busy;

    logic w_tick;
    logic w_sel_diff;

    // Strobes are single-cycle qualifiers with no backpressure: a sample is
    // accepted in any cycle its valid is high, and its result appears one
    // cycle later with the matching dout_valid. The R strobe closes a frame.
    assign w_tick     = r_din_valid & run;
    assign w_sel_diff = (sel_req != r_mux_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_MUTE;
            r_gain    <= '0;
            r_mux_sel <= 2'd0;
            r_settle  <= '0;
            r_busy    <= 1'b0;
        end else if (!run) begin
            r_state  <= ST_MUTE;
            r_gain   <= '0;
            r_settle <= '0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_MUTE: begin
                    r_gain    <= '0;
                    r_mux_sel <= sel_req;
                    r_settle  <= SETTLE_LOAD;
                    r_state   <= ST_SWITCH;
                    r_busy    <= 1'b1;
                end
                ST_SWITCH: begin
                    r_gain <= '0;
                    if (w_sel_diff) begin
                        r_mux_sel <= sel_req;
                        r_settle  <= SETTLE_LOAD;
                    end else if (r_settle == '0) begin
                        r_state <= ST_FADE_IN;
                    end else if (w_tick) begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                ST_FADE_IN: begin
                    if (w_sel_diff) begin
                        r_state <= ST_FADE_OUT;
                    end else if (r_gain == FULL) begin
                        r_state <= ST_PLAY;
                        r_busy  <= 1'b0;
                    end else if (w_tick) begin
                        r_gain <= r_gain + 1'b1;
                    end
                end
                ST_PLAY: begin
                    r_gain <= FULL;
                    if (w_sel_diff) begin
                        r_state <= ST_FADE_OUT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FADE_OUT: begin
                    // A request returning to the live source reverses the ramp in place.
                    if (!w_sel_diff) begin
                        r_state <= ST_FADE_IN;
                    end else if (r_gain == '0) begin
                        r_mux_sel <= sel_req;
                        r_settle  <= SETTLE_LOAD;
                        r_state   <= ST_SWITCH;
                    end else if (w_tick) begin
                        r_gain <= r_gain - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_MUTE;
                    r_gain  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    audio_gain_stage #(
        .DATA_W    (DATA_W),
        .RAMP_LOG2 (RAMP_LOG2)
    ) u_gain_l (
        .clk     (clk),
        .reset   (reset),
        .i_valid (l_din_valid & run),
        .i_din   (l_din),
        .i_gain  (r_gain),
        .o_valid (l_dout_valid),
        .o_dout  (l_dout)
    );

    audio_gain_stage #(
        .DATA_W    (DATA_W),
        .RAMP_LOG2 (RAMP_LOG2)
    ) u_gain_r (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_din_valid & run),
        .i_din   (r_din),
        .i_gain  (r_gain),
        .o_valid (r_dout_valid),
        .o_dout  (r_dout)
    );

    assign mux_sel = r_mux_sel;
    assign busy    = r_busy;
    assign state   = r_state;

endmodule

// File: tb/tb_audio_source_switch_ctrl.sv
// Bench for audio_source_switch_ctrl: directed fade/switch scenarios plus random
// frames, sel changes and run drops, checked against a source/gain/settle model.
module tb_audio_source_switch_ctrl;

    localparam int DATA_W    = 24;
    localparam int RAMP_LOG2 = 6;
    localparam int SETTLE    = 2;
    localparam int FULL      = 1 << RAMP_LOG2;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [1:0]        sel_req;
    logic [1:0]        mux_sel;
    logic              l_din_valid, r_din_valid;
    logic [DATA_W-1:0] l_din, r_din;
    logic              l_dout_valid, r_dout_valid;
    logic [DATA_W-1:0] l_dout, r_dout;
    logic              busy;
    logic [2:0]        state;

    audio_source_switch_ctrl #(
        .DATA_W        (DATA_W),
        .RAMP_LOG2     (RAMP_LOG2),
        .SETTLE_FRAMES (SETTLE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .sel_req      (sel_req),
        .mux_sel      (mux_sel),
        .l_din_valid  (l_din_valid),
        .r_din_valid  (r_din_valid),
        .l_din        (l_din),
        .r_din        (r_din),
        .l_dout_valid (l_dout_valid),
        .r_dout_valid (r_dout_valid),
        .l_dout       (l_dout),
        .r_dout       (r_dout),
        .busy         (busy),
        .state        (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] exp_l_q[$];
    logic [DATA_W-1:0] exp_r_q[$];

    // Model: which source is live, current gain, frames of settling left.
    bit m_on;
    int m_src;
    int m_gain;
    int m_settle;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] din, input int g);
        longint p;
        p = longint'($signed(din)) * longint'(g);
        return DATA_W'(p >>> RAMP_LOG2);
    endfunction

    // Observable phase follows from the model variables.
    function automatic int m_state();
        if (!m_on)              return 0;
        if (m_settle > 0)       return 4;
        if (sel_req != m_src)   return 3;
        if (m_gain < FULL)      return 1;
        return 2;
    endfunction

    task automatic model_norm();
        if (!run) begin
            m_on = 0; m_gain = 0; m_settle = 0;
            return;
        end
        if (!m_on) begin
            m_on = 1; m_src = int'(sel_req); m_settle = SETTLE;
        end
        if (sel_req != m_src && (m_settle > 0 || m_gain == 0)) begin
            m_src = int'(sel_req); m_settle = SETTLE;
        end
    endtask

    task automatic model_tick();
        case (m_state())
            4: m_settle--;
            1: m_gain++;
            3: m_gain--;
            default: ;
        endcase
        model_norm();
    endtask

    task automatic model_reset();
        m_on = 0; m_src = 0; m_gain = 0; m_settle = 0;
        exp_l_q.delete();
        exp_r_q.delete();
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status();
        int s;
        s = m_state();
        check("state", state, s);
        check("mux_sel", mux_sel, m_src);
        check("busy", busy, (s == 1 || s == 3 || s == 4));
    endtask

    // driver: one cycle of strobes, outputs checked the cycle after
    task automatic do_frame(input bit vl, input bit vr,
                            input logic [DATA_W-1:0] dl, input logic [DATA_W-1:0] dr);
        bit el, er;
        el = vl && run;
        er = vr && run;
        if (el) exp_l_q.push_back(scale(dl, m_gain));
        if (er) exp_r_q.push_back(scale(dr, m_gain));
        if (er) model_tick();
        l_din_valid = vl; r_din_valid = vr;
        l_din = dl; r_din = dr;
        @(posedge clk);
        #1;
        l_din_valid = 1'b0; r_din_valid = 1'b0;
        check("l_dout_valid", l_dout_valid, el);
        check("r_dout_valid", r_dout_valid, er);
        if (el) check("l_dout", l_dout, exp_l_q.pop_front());
        if (er) check("r_dout", r_dout, exp_r_q.pop_front());
    endtask

    task automatic frame_both(input logic [DATA_W-1:0] d);
        do_frame(1'b1, 1'b1, d, d);
        step(4);
        check("idle_l_valid", l_dout_valid, 1'b0);
        check_status();
    endtask

    task automatic set_sel(input logic [1:0] v);
        sel_req = v;
        model_norm();
        step(4);
        check_status();
    endtask

    task automatic set_run(input logic v);
        run = v;
        model_norm();
        step(4);
        check_status();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; sel_req = 2'd0;
        l_din_valid = 1'b0; r_din_valid = 1'b0; l_din = '0; r_din = '0;
        model_reset();
        step(3);
        reset = 1'b0;
        step(1);
        check("rst_state", state, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_l_valid", l_dout_valid, 0);
        check("rst_r_valid", r_dout_valid, 0);
        check("rst_l_dout", l_dout, 0);
        check("rst_r_dout", r_dout, 0);

        // start-up on source 2
        sel_req = 2'd2;
        run = 1'b1;
        model_norm();
        step(1);
        check("startup_mux_sel", mux_sel, 2);
        step(3);
        for (int f = 0; f <= 66; f++) begin
            if (f == 66) check("startup_play", state, 2);
            frame_both(24'h100000);
            check("startup_ramp", l_dout, (f < 2) ? 0 : ((f - 2) << 14));
        end

        // switch 2 -> 1
        set_sel(2'd1);
        for (int j = 0; j < 64; j++) begin
            check("sw_mux_hold", mux_sel, 2);
            check("sw_busy_out", busy, 1);
            frame_both(24'h100000);
            check("sw_fade_out", r_dout, (64 - j) << 14);
        end
        check("sw_mux_new", mux_sel, 1);
        for (int k = 0; k < 2 + 64; k++) begin
            check("sw_busy_in", busy, 1);
            frame_both(24'h100000);
            check("sw_fade_in", l_dout, (k < 2) ? 0 : ((k - 2) << 14));
        end
        frame_both(24'h100000);
        check("sw_full", l_dout, 24'h100000);
        check("sw_play_busy", busy, 0);

        // reversal at gain 40
        set_sel(2'd2);
        for (int j = 0; j < 24; j++) frame_both(24'h100000);
        set_sel(2'd1);
        check("rev_state", state, 1);
        for (int i = 0; i < 24; i++) begin
            frame_both(24'h100000);
            check("rev_ramp", l_dout, (40 + i) << 14);
            check("rev_mux", mux_sel, 1);
        end
        check("rev_play", state, 2);

        // negative full scale
        frame_both(24'h800000);
        check("neg_full", l_dout, 24'h800000);
        set_sel(2'd3);
        for (int j = 0; j < 32; j++) frame_both(24'($urandom));
        set_sel(2'd1);
        frame_both(24'h800000);
        check("neg_half", r_dout, 24'hC00000);
        for (int j = 0; j < 31; j++) frame_both(24'($urandom));
        check("neg_play", state, 2);

        // run drop mid fade-in
        set_sel(2'd0);
        for (int j = 0; j < 64 + 2 + 10; j++) frame_both(24'h100000);
        run = 1'b0;
        model_norm();
        do_frame(1'b1, 1'b1, 24'h100000, 24'h100000);
        check("rundrop_state", state, 0);
        step(4);
        check_status();
        set_run(1'b1);
        check("rerun_state", state, 4);
        for (int k = 0; k < 4; k++) begin
            frame_both(24'h100000);
            check("rerun_ramp", l_dout, (k < 3) ? 0 : (1 << 14));
        end

        // reset mid fade with samples in flight
        set_sel(2'd2);
        for (int j = 0; j < 5; j++) frame_both(24'h100000);
        reset = 1'b1;
        l_din_valid = 1'b1; r_din_valid = 1'b1;
        @(posedge clk);
        #1;
        l_din_valid = 1'b0; r_din_valid = 1'b0;
        check("rstmid_l_valid", l_dout_valid, 0);
        check("rstmid_r_valid", r_dout_valid, 0);
        check("rstmid_state", state, 0);
        check("rstmid_mux", mux_sel, 0);
        reset = 1'b0;
        model_reset();
        model_norm();
        step(4);
        check_status();

        // random traffic
        for (int it = 0; it < 1200; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (!run && r < 30) begin
                set_run(1'b1);
            end else if (r < 4) begin
                set_sel(2'($urandom_range(0, 3)));
            end else if (r < 6) begin
                set_run(1'b0);
            end else begin
                int mode;
                mode = $urandom_range(0, 3);
                do_frame(mode != 3, mode != 2, 24'($urandom), 24'($urandom));
                step($urandom_range(4, 6));
                check_status();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
